ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. It sits between the ID/EX register and the MEM stage.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages, selects the ALU B source, and computes the ALU result and the beq equality flag.
- Runs a multi-cycle shift-add multiplier that stalls the front of the pipe while busy.
- Registers everything into the EX/MEM pipeline register, whose outputs feed the MEM stage directly.

---
 rtl/ex_pkg.sv | 23 ++
 rtl/ex_stage_seq_multiplier.sv | 70 +++++++
 rtl/ex_stage.sv | 158 +++++++++++++++
 tb/tb_ex_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
// Holds ALU op codes and the multiplier state encoding.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_MUL = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle.
// Ports: clock, reset, start, flush, operand_a/b in; busy, done, product out.
import ex_pkg::*;

module seq_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    mul_state_t        state;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= operand_a;
                        mplier <= operand_b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The start cycle already stalls so the operands stay put.
    assign busy    = (state == ST_IDLE && start) || state == ST_BUSY;
    assign done    = (state == ST_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, beq compare, EX/MEM register.
// Ports: ID/EX operands+controls, forwarding sources, flush in; stall + EX/MEM out.
import ex_pkg::*;

module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              beq_instruction_in,
    input  logic              alu_src_in,
    input  logic [3:0]        alu_op_in,
    input  logic [DATA_W-1:0] rs1_data_in,
    input  logic [DATA_W-1:0] rs2_data_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_AW-1:0] rs1_addr_in,
    input  logic [REG_AW-1:0] rs2_addr_in,
    input  logic [REG_AW-1:0] reg_rd_in,
    input  logic [REG_AW-1:0] ex_mem_reg_rd,
    input  logic              ex_mem_reg_write,
    input  logic [DATA_W-1:0] alu_ex_mem,
    input  logic [REG_AW-1:0] mem_wb_reg_rd,
    input  logic              mem_wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              beq_instruction_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] mux2_result_out,
    output logic              flag_beq_out,
    output logic [REG_AW-1:0] reg_rd_out
);

    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_y;
    logic              beq_eq;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              kill;

    logic ex_hit1, wb_hit1, ex_hit2, wb_hit2;

    assign ex_hit1 = ex_mem_reg_write && ex_mem_reg_rd != '0
                     && ex_mem_reg_rd == rs1_addr_in;
    assign wb_hit1 = mem_wb_reg_write && mem_wb_reg_rd != '0
                     && mem_wb_reg_rd == rs1_addr_in;
    assign ex_hit2 = ex_mem_reg_write && ex_mem_reg_rd != '0
                     && ex_mem_reg_rd == rs2_addr_in;
    assign wb_hit2 = mem_wb_reg_write && mem_wb_reg_rd != '0
                     && mem_wb_reg_rd == rs2_addr_in;

    always_comb begin
        fwd_rs1 = rs1_data_in;
        if (ex_hit1) begin
            fwd_rs1 = alu_ex_mem;
        end else if (wb_hit1) begin
            fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_in;
        if (ex_hit2) begin
            fwd_rs2 = alu_ex_mem;
        end else if (wb_hit2) begin
            fwd_rs2 = wb_data;
        end
    end

    assign op_b   = alu_src_in ? imm_in : fwd_rs2;
    assign beq_eq = (fwd_rs1 == fwd_rs2);

    // MUL goes through the sequential unit; its single-cycle slot is 0.
    always_comb begin
        alu_y = '0;
        case (alu_op_in)
            ALU_ADD: alu_y = fwd_rs1 + op_b;
            ALU_SUB: alu_y = fwd_rs1 - op_b;
            ALU_AND: alu_y = fwd_rs1 & op_b;
            ALU_OR:  alu_y = fwd_rs1 | op_b;
            ALU_XOR: alu_y = fwd_rs1 ^ op_b;
            ALU_SLT: alu_y = {{(DATA_W-1){1'b0}},
                              $signed(fwd_rs1) < $signed(op_b)};
            ALU_SLL: alu_y = fwd_rs1 << op_b[4:0];
            ALU_SRL: alu_y = fwd_rs1 >> op_b[4:0];
            default: alu_y = '0;
        endcase
    end

    // Gated by reset so an in-reset MUL does not raise stall.
    assign mul_start = reset && !flush && reg_write_in
                       && (alu_op_in == ALU_MUL);

    seq_multiplier #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clock    (clock),
        .reset    (reset),
        .start    (mul_start),
        .flush    (flush),
        .operand_a(fwd_rs1),
        .operand_b(op_b),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (mul_product)
    );

    assign stall_out = mul_busy;
    assign kill      = flush || mul_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_to_reg_out      <= 1'b0;
            reg_write_out       <= 1'b0;
            mem_read_out        <= 1'b0;
            mem_write_out       <= 1'b0;
            beq_instruction_out <= 1'b0;
            alu_result_out      <= '0;
            mux2_result_out     <= '0;
            flag_beq_out        <= 1'b0;
            reg_rd_out          <= '0;
        end else if (kill) begin
            mem_to_reg_out      <= 1'b0;
            reg_write_out       <= 1'b0;
            mem_read_out        <= 1'b0;
            mem_write_out       <= 1'b0;
            beq_instruction_out <= 1'b0;
            alu_result_out      <= '0;
            mux2_result_out     <= '0;
            flag_beq_out        <= 1'b0;
            reg_rd_out          <= '0;
        end else begin
            mem_to_reg_out      <= mem_to_reg_in;
            reg_write_out       <= reg_write_in;
            mem_read_out        <= mem_read_in;
            mem_write_out       <= mem_write_in;
            beq_instruction_out <= beq_instruction_in;
            alu_result_out      <= mul_done ? mul_product : alu_y;
            mux2_result_out     <= fwd_rs2;
            flag_beq_out        <= beq_eq;
            reg_rd_out          <= reg_rd_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage.
// Expected EX/MEM contents are queued at issue and popped at capture.
import ex_pkg::*;

module tb_ex_stage;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        beq;
        logic [31:0] alu;
        logic [31:0] mux2;
        logic        flag;
        logic [4:0]  rd;
    } out_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_to_reg_in, reg_write_in, mem_read_in;
    logic        mem_write_in, beq_instruction_in, alu_src_in;
    logic [3:0]  alu_op_in;
    logic [31:0] rs1_data_in, rs2_data_in, imm_in;
    logic [4:0]  rs1_addr_in, rs2_addr_in, reg_rd_in;
    logic [4:0]  ex_mem_reg_rd, mem_wb_reg_rd;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [31:0] alu_ex_mem, wb_data;
    logic        flush;
    logic        stall_out;
    logic        mem_to_reg_out, reg_write_out, mem_read_out;
    logic        mem_write_out, beq_instruction_out, flag_beq_out;
    logic [31:0] alu_result_out, mux2_result_out;
    logic [4:0]  reg_rd_out;

    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];
    out_t got, e;

    always #5 clock = ~clock;

    ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_to_reg_in      (mem_to_reg_in),
        .reg_write_in       (reg_write_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .beq_instruction_in (beq_instruction_in),
        .alu_src_in         (alu_src_in),
        .alu_op_in          (alu_op_in),
        .rs1_data_in        (rs1_data_in),
        .rs2_data_in        (rs2_data_in),
        .imm_in             (imm_in),
        .rs1_addr_in        (rs1_addr_in),
        .rs2_addr_in        (rs2_addr_in),
        .reg_rd_in          (reg_rd_in),
        .ex_mem_reg_rd      (ex_mem_reg_rd),
        .ex_mem_reg_write   (ex_mem_reg_write),
        .alu_ex_mem         (alu_ex_mem),
        .mem_wb_reg_rd      (mem_wb_reg_rd),
        .mem_wb_reg_write   (mem_wb_reg_write),
        .wb_data            (wb_data),
        .flush              (flush),
        .stall_out          (stall_out),
        .mem_to_reg_out     (mem_to_reg_out),
        .reg_write_out      (reg_write_out),
        .mem_read_out       (mem_read_out),
        .mem_write_out      (mem_write_out),
        .beq_instruction_out(beq_instruction_out),
        .alu_result_out     (alu_result_out),
        .mux2_result_out    (mux2_result_out),
        .flag_beq_out       (flag_beq_out),
        .reg_rd_out         (reg_rd_out)
    );

    function automatic out_t sample();
        out_t s;
        s.m2r  = mem_to_reg_out;
        s.rw   = reg_write_out;
        s.mr   = mem_read_out;
        s.mw   = mem_write_out;
        s.beq  = beq_instruction_out;
        s.alu  = alu_result_out;
        s.mux2 = mux2_result_out;
        s.flag = flag_beq_out;
        s.rd   = reg_rd_out;
        return s;
    endfunction

    function automatic out_t mk(input logic [4:0] c,
                                input logic [31:0] alu,
                                input logic [31:0] mux2,
                                input logic flag,
                                input logic [4:0] rd);
        out_t s;
        {s.m2r, s.rw, s.mr, s.mw, s.beq} = c;
        s.alu  = alu;
        s.mux2 = mux2;
        s.flag = flag;
        s.rd   = rd;
        return s;
    endfunction

    // ctrl = {mem_to_reg, reg_write, mem_read, mem_write, beq}
    task automatic drive(input logic [3:0] op,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic src,
                         input logic [4:0] rd, input logic [4:0] ctrl);
        alu_op_in   = op;
        rs1_addr_in = a1;
        rs1_data_in = d1;
        rs2_addr_in = a2;
        rs2_data_in = d2;
        imm_in      = imm;
        alu_src_in  = src;
        reg_rd_in   = rd;
        {mem_to_reg_in, reg_write_in, mem_read_in,
         mem_write_in, beq_instruction_in} = ctrl;
        ex_mem_reg_rd    = 5'd0;
        ex_mem_reg_write = 1'b0;
        alu_ex_mem       = 32'd0;
        mem_wb_reg_rd    = 5'd0;
        mem_wb_reg_write = 1'b0;
        wb_data          = 32'd0;
        flush            = 1'b0;
    endtask

    task automatic nop();
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 5'b0);
    endtask

    task automatic test_reset();
        drive(ALU_MUL, 1, 32'h55, 2, 32'h66, 0, 0, 7, 5'b11111);
        reset = 1'b0;
        #3;
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_out got=%h exp=0", got);
        end
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", stall_out);
        end
        nop();
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_add();
        drive(ALU_ADD, 1, 7, 2, 5, 0, 0, 4, 5'b11010);
        exp_q.push_back(mk(5'b11010, 12, 5, 0, 4));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_fwd_priority();
        drive(ALU_SUB, 3, 1, 4, 7, 40, 1, 8, 5'b01000);
        ex_mem_reg_rd    = 3;
        ex_mem_reg_write = 1;
        alu_ex_mem       = 100;
        mem_wb_reg_rd    = 3;
        mem_wb_reg_write = 1;
        wb_data          = 200;
        exp_q.push_back(mk(5'b01000, 60, 7, 0, 8));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fwd_exmem got=%h exp=%h", got, e);
        end
        ex_mem_reg_rd = 0;
        exp_q.push_back(mk(5'b01000, 160, 7, 0, 8));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fwd_memwb got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_beq();
        drive(ALU_SUB, 6, 0, 2, 9, 0, 0, 0, 5'b00001);
        mem_wb_reg_rd    = 6;
        mem_wb_reg_write = 1;
        wb_data          = 9;
        exp_q.push_back(mk(5'b00001, 0, 9, 1, 0));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL beq got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_mul();
        int n = 0;
        int bub = 0;
        drive(ALU_MUL, 1, 32'hFFFF_FFFF, 2, 3, 0, 0, 9, 5'b01000);
        exp_q.push_back(mk(5'b01000, 32'hFFFF_FFFD, 3, 0, 9));
        #1;
        while (stall_out === 1'b1 && n < 50) begin
            n++;
            @(posedge clock);
            #1;
            if (sample() !== '0) bub++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL mul_stall_cycles got=%0d exp=33", n);
        end
        checks++;
        if (bub != 0) begin
            errors++;
            $display("FAIL mul_bubbles got=%0d nonbubble exp=0", bub);
        end
        @(posedge clock);
        #1;
        nop();
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mul_result got=%h exp=%h", got, e);
        end
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL mul_no_restart got=%b exp=0", stall_out);
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        drive(ALU_MUL, 1, 32'd1234, 2, 32'd77, 0, 0, 10, 5'b01000);
        repeat (11) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1;
        nop();
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got=%b exp=0", stall_out);
        end
        repeat (40) begin
            @(posedge clock);
            #1 if (reg_write_out !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_result got=%0d writes exp=0", seen);
        end
        drive(ALU_MUL, 1, 32'd5, 2, 32'd6, 0, 0, 11, 5'b01000);
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (sample() !== '0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got=%h stall=%b exp=0",
                     sample(), stall_out);
        end
        nop();
        @(posedge clock);
        #1 reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (reg_write_out !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_result got=%0d writes exp=0", seen);
        end
        drive(ALU_ADD, 1, 2, 2, 3, 0, 0, 12, 5'b01000);
        exp_q.push_back(mk(5'b01000, 5, 3, 0, 12));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL after_reset_add got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_flush_start();
        drive(ALU_MUL, 1, 32'd3, 2, 32'd4, 0, 0, 13, 5'b01000);
        flush = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_mul_stall got=%b exp=0", stall_out);
        end
        drive(ALU_ADD, 1, 2, 2, 3, 0, 0, 14, 5'b11000);
        flush = 1'b1;
        @(posedge clock);
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL flush_bubble got=%h exp=0", got);
        end
        nop();
    endtask

    task automatic test_slt_sll();
        drive(ALU_SLT, 1, 32'hFFFF_FFFE, 0, 0, 1, 1, 2, 5'b01000);
        exp_q.push_back(mk(5'b01000, 1, 0, 0, 2));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL slt got=%h exp=%h", got, e);
        end
        drive(ALU_SLL, 1, 1, 0, 0, 35, 1, 3, 5'b01000);
        exp_q.push_back(mk(5'b01000, 8, 0, 0, 3));
        @(posedge clock);
        #1;
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL sll got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, r;
        logic [3:0]  op;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? a : $urandom;
            op = 4'($urandom_range(0, 4));
            case (op)
                ALU_ADD: r = a + b;
                ALU_SUB: r = a - b;
                ALU_AND: r = a & b;
                ALU_OR:  r = a | b;
                default: r = a ^ b;
            endcase
            drive(op, 1, a, 2, b, 0, 0, 5'(i + 1), 5'b01000);
            exp_q.push_back(mk(5'b01000, r, b, a == b, 5'(i + 1)));
            @(posedge clock);
            #1;
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        nop();
        test_reset();
        test_add();
        test_fwd_priority();
        test_beq();
        test_mul();
        test_abort();
        test_flush_start();
        test_slt_sll();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
